// File: rtl/pe_ctrl_sequencer.sv
// pe_ctrl_sequencer: builds the per-cycle PE control word for a layer job.
// The job is num_passes accumulation passes over num_outputs buffer entries,
// with num_macc MACC beats per entry. Pass 0 accumulates onto the bias.
// Each later pass reads the partial sum back from the PE buffer. The final
// pass emits results on write_valid and does not write the buffer.
//
// state | meaning
// IDLE  | cfg_ready high, waiting for a configuration
// RUN   | consuming operand beats, issuing enable/read strobes
// DRAIN | MACC_LATENCY cycles so the delayed write strobes leave the pipe
// DONE  | one-cycle done pulse, then back to IDLE
module pe_ctrl_sequencer #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int MACC_LATENCY      = 3,
    parameter int CNT_WIDTH         = 16,
    parameter int PASS_WIDTH        = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [CNT_WIDTH-1:0]             cfg_num_macc,
    input  logic [PE_BUF_ADDR_WIDTH:0]       cfg_num_outputs,
    input  logic [PASS_WIDTH-1:0]            cfg_num_passes,
    input  logic [2:0]                       cfg_op_code,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [9+2*PE_BUF_ADDR_WIDTH:0]   ctrl,
    output logic                             src_2_sel,
    output logic                             done
);

    localparam int AW = PE_BUF_ADDR_WIDTH;
    localparam int DW = $clog2(MACC_LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   macc_q;
    logic [AW:0]            outputs_q;
    logic [PASS_WIDTH-1:0]  passes_q;
    logic [2:0]             op_code_q;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [AW-1:0]          out_cnt;
    logic [PASS_WIDTH-1:0]  pass_cnt;
    logic [DW-1:0]          drain_cnt;

    // Delayed write strobes, one slot per MACC pipeline stage.
    logic                   pipe_wr_req [MACC_LATENCY];
    logic                   pipe_wv     [MACC_LATENCY];
    logic [AW-1:0]          pipe_addr   [MACC_LATENCY];

    logic                   beat;
    logic                   last_beat;
    logic                   last_out;
    logic                   last_pass;
    logic                   push;
    logic                   read_req;
    logic [AW-1:0]          rd_addr;

    // A beat is an operand transfer; every counter advances only on beats.
    assign beat      = (state == RUN) && in_valid;
    assign last_beat = (beat_cnt == macc_q - CNT_WIDTH'(1));
    // Compared in AW+1 bits so num_outputs = 2^AW ends on the all-ones address.
    assign last_out  = (({1'b0, out_cnt} + (AW+1)'(1)) == outputs_q);
    assign last_pass = (pass_cnt == passes_q - PASS_WIDTH'(1));
    assign push      = beat && last_beat;
    assign read_req  = beat && (beat_cnt == '0) && (pass_cnt != '0);
    assign rd_addr   = read_req ? out_cnt : '0;

    // Sequencing FSM with job configuration and loop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            macc_q    <= '0;
            outputs_q <= '0;
            passes_q  <= '0;
            op_code_q <= '0;
            beat_cnt  <= '0;
            out_cnt   <= '0;
            pass_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        macc_q    <= cfg_num_macc;
                        outputs_q <= cfg_num_outputs;
                        passes_q  <= cfg_num_passes;
                        beat_cnt  <= '0;
                        out_cnt   <= '0;
                        pass_cnt  <= '0;
                        if ((cfg_num_macc == '0) || (cfg_num_outputs == '0) ||
                            (cfg_num_passes == '0)) begin
                            state <= DONE;
                        end else begin
                            op_code_q <= cfg_op_code;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            if (last_out) begin
                                out_cnt   <= '0;
                                drain_cnt <= DW'(MACC_LATENCY - 1);
                                state     <= DRAIN;
                            end else begin
                                out_cnt <= out_cnt + AW'(1);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        if (last_pass) begin
                            op_code_q <= '0;
                            state     <= DONE;
                        end else begin
                            pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                            state    <= RUN;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-strobe delay line; it shifts every cycle, stalls included.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MACC_LATENCY; i++) begin
                pipe_wr_req[i] <= 1'b0;
                pipe_wv[i]     <= 1'b0;
                pipe_addr[i]   <= '0;
            end
        end else begin
            pipe_wr_req[0] <= push && !last_pass;
            pipe_wv[0]     <= push && last_pass;
            pipe_addr[0]   <= (push && !last_pass) ? out_cnt : '0;
            for (int i = 1; i < MACC_LATENCY; i++) begin
                pipe_wr_req[i] <= pipe_wr_req[i-1];
                pipe_wv[i]     <= pipe_wv[i-1];
                pipe_addr[i]   <= pipe_addr[i-1];
            end
        end
    end

    assign cfg_ready = (state == IDLE);
    assign in_ready  = (state == RUN);
    assign done      = (state == DONE);
    assign src_2_sel = ((state == RUN) || (state == DRAIN)) && (pass_cnt != '0);

    // Norm FIFO and flush controls are unused by this sequencer and held low.
    assign ctrl = {2'b00,
                   rd_addr,
                   pipe_addr[MACC_LATENCY-1],
                   1'b0,
                   pipe_wv[MACC_LATENCY-1],
                   pipe_wr_req[MACC_LATENCY-1],
                   read_req,
                   beat,
                   op_code_q};

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Directed bench for pe_ctrl_sequencer: runs small jobs, logs every cycle
// relative to the configuration cycle and checks hand-computed timings.
module tb_pe_ctrl_sequencer;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_num_macc;
    logic [10:0] cfg_num_outputs;
    logic [7:0]  cfg_num_passes;
    logic [2:0]  cfg_op_code;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] ctrl;
    logic        src_2_sel;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    localparam int LOG_N = 2100;
    logic [29:0] ctrl_log [LOG_N];
    logic        done_log [LOG_N];
    logic        src_log  [LOG_N];
    logic        inr_log  [LOG_N];
    logic        cfgr_log [LOG_N];
    int          ncyc_last;

    pe_ctrl_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_num_macc    (cfg_num_macc),
        .cfg_num_outputs (cfg_num_outputs),
        .cfg_num_passes  (cfg_num_passes),
        .cfg_op_code     (cfg_op_code),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .ctrl            (ctrl),
        .src_2_sel       (src_2_sel),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ctrl bit positions: 3 enable, 4 read_req, 5 write_req, 6 write_valid
    function automatic int count_bit(input int b);
        int c = 0;
        for (int k = 0; k < ncyc_last; k++) c += int'(ctrl_log[k][b]);
        return c;
    endfunction

    function automatic int count_done();
        int c = 0;
        for (int k = 0; k < ncyc_last; k++) c += int'(done_log[k]);
        return c;
    endfunction

    // Cycle 0 offers the configuration; mode 0 holds in_valid high from cycle 1,
    // mode 1 raises it on odd cycles only. rst_at < 0 means no reset.
    task automatic run_job(input logic [15:0] macc, input logic [10:0] outs,
                           input logic [7:0] passes, input logic [2:0] op,
                           input int mode, input int ncyc, input int rst_at);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            cfg_valid       = (k == 0);
            cfg_num_macc    = macc;
            cfg_num_outputs = outs;
            cfg_num_passes  = passes;
            cfg_op_code     = op;
            in_valid        = (mode == 0) ? (k >= 1) : ((k % 2) == 1);
            reset           = (k == rst_at);
            @(negedge clk);
            ctrl_log[k] = ctrl;
            done_log[k] = done;
            src_log[k]  = src_2_sel;
            inr_log[k]  = in_ready;
            cfgr_log[k] = cfg_ready;
        end
        ncyc_last = ncyc;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0;
        cfg_num_macc = '0; cfg_num_outputs = '0; cfg_num_passes = '0; cfg_op_code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ctrl", ctrl, 0);
        check_val("rst_cfg_ready", cfg_ready, 1);
        check_val("rst_done", done, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_src2", src_2_sel, 0);
        @(posedge clk); #1; reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("idle_ctrl", ctrl, 0);
        check_val("idle_cfg_ready", cfg_ready, 1);

        // Reset mid-RUN: last beat of out 0 at cycle 4 would give write_valid at 7.
        run_job(16'd4, 11'd2, 8'd1, 3'd3, 0, 12, 5);
        check_val("mr_en_c4", ctrl_log[4][3], 1);
        check_val("mr_ctrl_c6", ctrl_log[6], 0);
        check_val("mr_cfg_ready_c6", cfgr_log[6], 1);
        check_val("mr_ctrl_c7", ctrl_log[7], 0);
        check_val("mr_wv_cnt", count_bit(6), 0);
        check_val("mr_done_cnt", count_done(), 0);

        // Single pass: beats 1..8, write_valid at 7 and 11, done at 12.
        run_job(16'd4, 11'd2, 8'd1, 3'd3, 0, 16, -1);
        check_val("t2_ctrl_c1", ctrl_log[1], 11);
        check_val("t2_en_cnt", count_bit(3), 8);
        check_val("t2_en_c9", ctrl_log[9][3], 0);
        check_val("t2_wv_cnt", count_bit(6), 2);
        check_val("t2_wv_c7", ctrl_log[7][6], 1);
        check_val("t2_wv_c11", ctrl_log[11][6], 1);
        check_val("t2_wr_cnt", count_bit(5), 0);
        check_val("t2_rd_cnt", count_bit(4), 0);
        check_val("t2_src2_c5", src_log[5], 0);
        check_val("t2_done_c12", done_log[12], 1);
        check_val("t2_done_cnt", count_done(), 1);
        check_val("t2_cfg_ready_c12", cfgr_log[12], 0);

        // Two passes, in_valid held high.
        run_job(16'd2, 11'd3, 8'd2, 3'd6, 0, 24, -1);
        check_val("t3_ctrl_c5", ctrl_log[5], 46);
        check_val("t3_ctrl_c7", ctrl_log[7], 294);
        check_val("t3_ctrl_c9", ctrl_log[9], 550);
        check_val("t3_ctrl_c10", ctrl_log[10], 30);
        check_val("t3_ctrl_c12", ctrl_log[12], 262174);
        check_val("t3_ctrl_c14", ctrl_log[14], 524382);
        check_val("t3_ctrl_c16", ctrl_log[16], 70);
        check_val("t3_ctrl_c18", ctrl_log[18], 70);
        check_val("t3_wr_cnt", count_bit(5), 3);
        check_val("t3_rd_cnt", count_bit(4), 3);
        check_val("t3_wv_cnt", count_bit(6), 3);
        check_val("t3_en_cnt", count_bit(3), 12);
        check_val("t3_src2_c9", src_log[9], 0);
        check_val("t3_src2_c10", src_log[10], 1);
        check_val("t3_done_c19", done_log[19], 1);
        check_val("t3_done_cnt", count_done(), 1);

        // Same job, in_valid toggling: beats only on odd cycles.
        run_job(16'd2, 11'd3, 8'd2, 3'd6, 1, 34, -1);
        check_val("t4_en_c2", ctrl_log[2][3], 0);
        check_val("t4_en_c3", ctrl_log[3][3], 1);
        check_val("t4_en_cnt", count_bit(3), 12);
        check_val("t4_wr_c6", ctrl_log[6][5], 1);
        check_val("t4_wr_addr_c10", ctrl_log[10][17:8], 1);
        check_val("t4_wr_addr_c14", ctrl_log[14][17:8], 2);
        check_val("t4_in_ready_c13", inr_log[13], 0);
        check_val("t4_rd_addr_c19", ctrl_log[19][27:18], 1);
        check_val("t4_rd_c23", ctrl_log[23][4], 1);
        check_val("t4_wv_c28", ctrl_log[28][6], 1);
        check_val("t4_wr_cnt", count_bit(5), 3);
        check_val("t4_rd_cnt", count_bit(4), 3);
        check_val("t4_wv_cnt", count_bit(6), 3);
        check_val("t4_done_c29", done_log[29], 1);

        // Zero outputs: done one cycle after acceptance, ctrl silent.
        run_job(16'd4, 11'd0, 8'd2, 3'd5, 0, 6, -1);
        check_val("t5_done_c1", done_log[1], 1);
        check_val("t5_done_cnt", count_done(), 1);
        check_val("t5_cfg_ready_c2", cfgr_log[2], 1);
        check_val("t5_ctrl_c1", ctrl_log[1], 0);
        check_val("t5_ctrl_c3", ctrl_log[3], 0);
        check_val("t5_en_cnt", count_bit(3), 0);

        // One beat, one output, three passes: read of addr 0 follows its write.
        run_job(16'd1, 11'd1, 8'd3, 3'd1, 0, 16, -1);
        check_val("t6_wr_c4", ctrl_log[4][5], 1);
        check_val("t6_rd_c4", ctrl_log[4][4], 0);
        check_val("t6_rd_c5", ctrl_log[5][4], 1);
        check_val("t6_en_c3", ctrl_log[3][3], 0);
        check_val("t6_wr_c8", ctrl_log[8][5], 1);
        check_val("t6_rd_c9", ctrl_log[9][4], 1);
        check_val("t6_wv_c12", ctrl_log[12][6], 1);
        check_val("t6_wr_cnt", count_bit(5), 2);
        check_val("t6_src2_c1", src_log[1], 0);
        check_val("t6_src2_c5", src_log[5], 1);
        check_val("t6_done_c13", done_log[13], 1);

        // Full-depth buffer: last address is all ones in both passes.
        run_job(16'd1, 11'd1024, 8'd2, 3'd2, 0, 2058, -1);
        check_val("t7_wr_addr_c1027", ctrl_log[1027][17:8], 1023);
        check_val("t7_wr_c1027", ctrl_log[1027][5], 1);
        check_val("t7_rd_addr_c2051", ctrl_log[2051][27:18], 1023);
        check_val("t7_src2_c2051", src_log[2051], 1);
        check_val("t7_wr_cnt", count_bit(5), 1024);
        check_val("t7_wv_cnt", count_bit(6), 1024);
        check_val("t7_done_c2055", done_log[2055], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
